// File: rtl/pdp8_ea_unit.sv
// -----------------------------------------------------------------------------
// pdp8_ea_unit
//
// Effective-address stage for PDP-8 memory-reference instructions. Latches an
// instruction and its PC on start, resolves page-zero / current-page direct
// addressing, performs the indirect pointer read and, for auto-index
// locations (page-zero 0010-0017 octal), the incremented pointer write-back
// through the memory_controller request/done handshake. The final 12-bit
// effective address is presented on eaddr with a one-cycle ea_done pulse.
//
// Optional feature macro: EA_TIMEOUT_EN
//   defined   : a per-WAIT-state cycle counter aborts a stalled memory
//               transaction after TIMEOUT_CYCLES cycles, raising a sticky
//               timeout_error and completing with eaddr = 0.
//   undefined : WAIT states wait indefinitely; timeout_error is tied low.
//
// Ports
//   clk                 system clock, all state on rising edge
//   reset               synchronous active-high reset
//   start               begin EA calculation (sampled only in IDLE)
//   instruction[11:0]   opcode[11:9], I[8], Z[7], offset[6:0]
//   pc[11:0]            address of the current instruction
//   mem_address[11:0]   memory_controller address
//   mem_write_data[11:0] memory_controller write data
//   mem_read_enable     memory_controller read request (one cycle)
//   mem_read_type       memory_controller read type, always DATA_READ
//   mem_write_enable    memory_controller write request (one cycle)
//   mem_read_data[11:0] memory_controller read data
//   mem_operation_done  memory_controller completion strobe
//   eaddr[11:0]         effective address, held until the next start
//   ea_done             one-cycle completion pulse
//   is_mri              opcode 0-5 flag, valid with ea_done
//   busy                high in every state except IDLE
//   timeout_error       sticky WAIT-state timeout flag
// -----------------------------------------------------------------------------

`ifndef DATA_READ
`define DATA_READ 1'b0
`endif

module pdp8_ea_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [11:0] instruction,
    input  logic [11:0] pc,
    output logic [11:0] mem_address,
    output logic [11:0] mem_write_data,
    output logic        mem_read_enable,
    output logic        mem_read_type,
    output logic        mem_write_enable,
    input  logic [11:0] mem_read_data,
    input  logic        mem_operation_done,
    output logic [11:0] eaddr,
    output logic        ea_done,
    output logic        is_mri,
    output logic        busy,
    output logic        timeout_error
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DECODE  = 3'd1,
        RD_REQ  = 3'd2,
        RD_WAIT = 3'd3,
        WR_REQ  = 3'd4,
        WR_WAIT = 3'd5,
        DONE    = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic [11:0] instr_q, instr_d;
    logic [4:0]  pc_page_q, pc_page_d;   // only the page bits of the PC matter
    logic [11:0] direct_q, direct_d;
    logic [11:0] ptr_q, ptr_d;
    logic [11:0] eaddr_q, eaddr_d;
    logic        is_mri_q, is_mri_d;

`ifdef EA_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
`endif

    // Fields of the latched instruction
    logic [2:0] opcode;
    logic       ind_bit;
    logic       zero_bit;
    logic [6:0] offset;
    logic       auto_index;
    logic [11:0] direct_calc;

    assign opcode   = instr_q[11:9];
    assign ind_bit  = instr_q[8];
    assign zero_bit = instr_q[7];
    assign offset   = instr_q[6:0];

    // Z=1 selects the current page, Z=0 selects page zero.
    assign direct_calc = zero_bit ? {pc_page_q, offset} : {5'b0, offset};

    // Auto-index locations are page-zero 0010-0017 octal reached indirectly.
    assign auto_index = ind_bit && !zero_bit && (offset[6:3] == 4'b0001);

    // The low PC bits are replaced by the offset; the parameter is only
    // consumed when the timeout counter is built.
    logic unused_bits;
    assign unused_bits = (^pc[6:0]) ^ (TIMEOUT_CYCLES == 0);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            instr_q   <= 12'd0;
            pc_page_q <= 5'd0;
            direct_q  <= 12'd0;
            ptr_q     <= 12'd0;
            eaddr_q   <= 12'd0;
            is_mri_q  <= 1'b0;
`ifdef EA_TIMEOUT_EN
            cnt_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            pc_page_q <= pc_page_d;
            direct_q  <= direct_d;
            ptr_q     <= ptr_d;
            eaddr_q   <= eaddr_d;
            is_mri_q  <= is_mri_d;
`ifdef EA_TIMEOUT_EN
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        pc_page_d = pc_page_q;
        direct_d  = direct_q;
        ptr_d     = ptr_q;
        eaddr_d   = eaddr_q;
        is_mri_d  = is_mri_q;
`ifdef EA_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    instr_d   = instruction;
                    pc_page_d = pc[11:7];
                    eaddr_d   = 12'd0;
                    is_mri_d  = 1'b0;
                    state_d   = DECODE;
                end
            end

            DECODE: begin
                direct_d = direct_calc;
                if (opcode >= 3'd6) begin
                    // IOT / OPR: no address, not a memory reference.
                    eaddr_d  = 12'd0;
                    is_mri_d = 1'b0;
                    state_d  = DONE;
                end else begin
                    is_mri_d = 1'b1;
                    if (!ind_bit) begin
                        eaddr_d = direct_calc;
                        state_d = DONE;
                    end else begin
                        state_d = RD_REQ;
                    end
                end
            end

            RD_REQ: begin
`ifdef EA_TIMEOUT_EN
                cnt_d = '0;
`endif
                state_d = RD_WAIT;
            end

            RD_WAIT: begin
                if (mem_operation_done) begin
                    if (auto_index) begin
                        ptr_d   = mem_read_data + 12'd1;
                        state_d = WR_REQ;
                    end else begin
                        eaddr_d = mem_read_data;
                        state_d = DONE;
                    end
                end
`ifdef EA_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    eaddr_d   = 12'd0;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end

            WR_REQ: begin
`ifdef EA_TIMEOUT_EN
                cnt_d = '0;
`endif
                state_d = WR_WAIT;
            end

            WR_WAIT: begin
                if (mem_operation_done) begin
                    eaddr_d = ptr_q;
                    state_d = DONE;
                end
`ifdef EA_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    eaddr_d   = 12'd0;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end

            DONE: begin
                // start is deliberately not sampled here.
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs (decoded from registered state, so glitch-free per cycle)
    // -------------------------------------------------------------------------
    logic in_rd, in_wr;
    assign in_rd = (state_q == RD_REQ) || (state_q == RD_WAIT);
    assign in_wr = (state_q == WR_REQ) || (state_q == WR_WAIT);

    assign mem_address      = (in_rd || in_wr) ? direct_q : 12'd0;
    assign mem_write_data   = in_wr ? ptr_q : 12'd0;
    assign mem_read_enable  = (state_q == RD_REQ);
    assign mem_write_enable = (state_q == WR_REQ);
    assign mem_read_type    = `DATA_READ;

    assign eaddr   = eaddr_q;
    assign is_mri  = is_mri_q;
    assign ea_done = (state_q == DONE);
    assign busy    = (state_q != IDLE);

`ifdef EA_TIMEOUT_EN
    assign timeout_error = timeout_q;
`else
    assign timeout_error = 1'b0;
`endif

endmodule
